// File: rtl/ad4003_pkg.sv
// Shared constants and types for the AD4003 serial-interface emulator.
// Holds the command opcodes, configuration-register bit positions and the FSM state type.
// Imported by the emulator top; no logic of its own.
package ad4003_pkg;

  localparam int ADC_DATA_WIDTH_DEFAULT = 18;

  // SDI command word: [15:8] opcode, [7:0] data.
  localparam int         CMD_BITS   = 16;
  localparam logic [7:0] CMD_WR_REG = 8'h14;
  localparam logic [7:0] CMD_RD_REG = 8'h54;

  // Configuration register layout.
  localparam int         CFG_TURBO_BIT   = 1;
  localparam int         CFG_OVCLAMP_BIT = 0;
  localparam logic [7:0] CFG_RESET       = 8'h00;

  // Frame bit counter width; the counter saturates at its all-ones value.
  localparam int BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/ad4003_emulator_if.sv
// Serial link between an acquisition master and the AD4003 (or this emulator).
// Signals: cnv (frame start), sck (serial clock), sdi (commands) from the master; sdo back to it.
// master modport drives cnv/sck/sdi, slave modport drives sdo.
interface ad4003_emulator_if;

  logic cnv;
  logic sck;
  logic sdi;
  logic sdo;

  modport master (output cnv, output sck, output sdi, input sdo);
  modport slave  (input cnv, input sck, input sdi, output sdo);

endinterface

// File: rtl/ad4003_edge_sync.sv
// Synchronizes one asynchronous pad input into clk_200 and flags its rising edges.
// Ports: din (async pad level) -> lvl (synchronized level), rise (registered one-cycle strobe).
// Latency: lvl after SYNC_STAGES clocks, rise one clock later.
module ad4003_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_200,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk_200 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;

endmodule

// File: rtl/ad4003_emulator.sv
// AD4003 far-end responder: latches sample_in on CNV, shifts it out MSB-first on SDO, decodes SDI register commands.
// Ports: clk_200/rst_n, adc_if (slave: cnv/sck/sdi in, sdo out), sample_in/sample_ack, busy, cfg_reg, cnv_err.
// Optional build macro ADC_EMU_RAMP_EN: replace sample_in with an internal ramp advancing by RAMP_STEP per latch.
module ad4003_emulator
  import ad4003_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = ADC_DATA_WIDTH_DEFAULT,
  parameter int CONV_CYCLES    = 64,
  parameter int SYNC_STAGES    = 2,
  parameter int RAMP_STEP      = 1
) (
  input  logic                      clk_200,
  input  logic                      rst_n,
  ad4003_emulator_if.slave          adc_if,
  input  logic [ADC_DATA_WIDTH-1:0] sample_in,
  output logic                      sample_ack,
  output logic                      busy,
  output logic [7:0]                cfg_reg,
  output logic                      cnv_err
);

  localparam int CONV_CNT_W = $clog2(CONV_CYCLES) + 1;

  logic cnv_rise, sck_rise, sdi_lvl;
  logic cnv_lvl_unused, sck_lvl_unused, sdi_rise_unused;

  ad4003_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cnv (
    .clk_200(clk_200), .rst_n(rst_n), .din(adc_if.cnv), .lvl(cnv_lvl_unused), .rise(cnv_rise));
  ad4003_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_200(clk_200), .rst_n(rst_n), .din(adc_if.sck), .lvl(sck_lvl_unused), .rise(sck_rise));
  ad4003_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk_200(clk_200), .rst_n(rst_n), .din(adc_if.sdi), .lvl(sdi_lvl), .rise(sdi_rise_unused));

  state_e                    state_q, state_d;
  logic [ADC_DATA_WIDTH-1:0] conv_q, conv_d;
  logic [ADC_DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CMD_BITS-1:0]       cmd_q, cmd_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CONV_CNT_W-1:0]     conv_cnt_q, conv_cnt_d;
  logic [7:0]                cfg_q, cfg_d;
  logic                      err_q, err_d;
  logic                      rd_arm_q, rd_arm_d;

  logic                      conv_done;
  logic                      cnv_accept;
  logic [ADC_DATA_WIDTH-1:0] load_word;
  logic [ADC_DATA_WIDTH-1:0] latch_val;

`ifdef ADC_EMU_RAMP_EN
  logic [ADC_DATA_WIDTH-1:0] ramp_q, ramp_d;
  logic [ADC_DATA_WIDTH-1:0] sample_in_unused;
  assign sample_in_unused = sample_in;
  assign latch_val        = ramp_q;
`else
  assign latch_val = sample_in;
`endif

  assign conv_done  = (state_q == ST_CONV) && (conv_cnt_q == CONV_CNT_W'(CONV_CYCLES - 1));
  // A CNV edge coinciding with the terminal count is treated as arriving in SHIFT.
  assign cnv_accept = cnv_rise && ((state_q != ST_CONV) || conv_done);
  // An armed read-back replaces exactly one frame's sample data.
  assign load_word  = rd_arm_q ? ADC_DATA_WIDTH'({cfg_q, 2'b00}) : conv_q;

  // State register
  always_ff @(posedge clk_200 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      conv_q     <= '0;
      shift_q    <= '0;
      cmd_q      <= '0;
      bit_cnt_q  <= '0;
      conv_cnt_q <= '0;
      cfg_q      <= CFG_RESET;
      err_q      <= 1'b0;
      rd_arm_q   <= 1'b0;
`ifdef ADC_EMU_RAMP_EN
      ramp_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      conv_q     <= conv_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      bit_cnt_q  <= bit_cnt_d;
      conv_cnt_q <= conv_cnt_d;
      cfg_q      <= cfg_d;
      err_q      <= err_d;
      rd_arm_q   <= rd_arm_d;
`ifdef ADC_EMU_RAMP_EN
      ramp_q     <= ramp_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    conv_d     = conv_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    bit_cnt_d  = bit_cnt_q;
    conv_cnt_d = conv_cnt_q;
    cfg_d      = cfg_q;
    err_d      = err_q;
    rd_arm_d   = rd_arm_q;
`ifdef ADC_EMU_RAMP_EN
    ramp_d     = ramp_q;
`endif

    case (state_q)
      ST_CONV: begin
        if (conv_done) begin
          shift_d  = load_word;
          rd_arm_d = 1'b0;
          state_d  = ST_SHIFT;
        end else begin
          conv_cnt_d = conv_cnt_q + CONV_CNT_W'(1);
          if (cnv_rise) err_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sck_rise) begin
          shift_d   = {shift_q[ADC_DATA_WIDTH-2:0], 1'b0};
          cmd_d     = {cmd_q[CMD_BITS-2:0], sdi_lvl};
          bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + BIT_CNT_W'(1);
          // Decode once, on the edge that completes the 16-bit command word.
          if (bit_cnt_q == BIT_CNT_W'(CMD_BITS - 1)) begin
            if (cmd_d[15:8] == CMD_WR_REG)      cfg_d    = cmd_d[7:0];
            else if (cmd_d[15:8] == CMD_RD_REG) rd_arm_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (cnv_accept) begin
      conv_d     = latch_val;
      bit_cnt_d  = '0;
      cmd_d      = '0;
      conv_cnt_d = '0;
`ifdef ADC_EMU_RAMP_EN
      ramp_d     = ramp_q + ADC_DATA_WIDTH'(RAMP_STEP);
`endif
      if (cfg_q[CFG_TURBO_BIT]) begin
        // Turbo returns the previous conversion, so load before conv_reg is overwritten.
        shift_d  = load_word;
        rd_arm_d = 1'b0;
        state_d  = ST_SHIFT;
      end else begin
        state_d  = ST_CONV;
      end
    end
  end

  // Outputs
  always_comb begin
    busy       = (state_q == ST_CONV);
    sample_ack = cnv_accept;
    adc_if.sdo = shift_q[ADC_DATA_WIDTH-1];
    cfg_reg    = cfg_q;
    cnv_err    = err_q;
  end

endmodule

// File: tb/tb_ad4003_emulator.sv
// Self-checking bench for ad4003_emulator: directed frames against a transaction-level model of the ADC.
// The master reads each SDO bit in the SCK low phase just before the rising edge that advances it.
// A per-cycle monitor checks cfg_reg/cnv_err/sample_ack against the model whenever the link is quiet.
module tb_ad4003_emulator;

  logic        clk_200;
  logic        rst_n;
  logic [17:0] sample_in;
  logic        sample_ack;
  logic        busy;
  logic [7:0]  cfg_reg;
  logic        cnv_err;

  ad4003_emulator_if adc_if();

  ad4003_emulator dut (
    .clk_200   (clk_200),
    .rst_n     (rst_n),
    .adc_if    (adc_if),
    .sample_in (sample_in),
    .sample_ack(sample_ack),
    .busy      (busy),
    .cfg_reg   (cfg_reg),
    .cnv_err   (cnv_err)
  );

  initial clk_200 = 1'b0;
  always #5 clk_200 = ~clk_200;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_total = 0;
  int ack_total  = 0;
  bit chk_en = 1'b0;

  // Transaction-level model of the ADC.
  logic [7:0]  m_cfg;
  logic [17:0] m_conv;
  logic        m_arm;
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_200) begin
    if (busy)       busy_total <= busy_total + 1;
    if (sample_ack) ack_total  <= ack_total + 1;
  end

  always @(negedge clk_200) begin
    if (chk_en) begin
      check("cyc_cfg_reg", 32'(cfg_reg), 32'(m_cfg));
      check("cyc_cnv_err", 32'(cnv_err), 32'(m_err));
      check("cyc_sample_ack_idle", 32'(sample_ack), 32'd0);
    end
  end

  function automatic logic [31:0] frame_bits(input logic [17:0] w, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], (i < 18) ? w[17-i] : 1'b0};
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_200);
    #1;
  endtask

  task automatic cnv_pulse();
    cycles(1);
    adc_if.cnv = 1'b1;
    cycles(4);
    adc_if.cnv = 1'b0;
  endtask

  task automatic shift_bits(input int n, input logic [15:0] cmd, output logic [31:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      adc_if.sdi = (i < 16) ? cmd[15-i] : 1'b0;
      cycles(6);
      rd = {rd[30:0], adc_if.sdo};
      adc_if.sck = 1'b1;
      cycles(6);
      adc_if.sck = 1'b0;
    end
    adc_if.sdi = 1'b0;
    cycles(8);
  endtask

  task automatic do_frame(input string name, input logic [17:0] smp, input logic [15:0] cmd,
                          input int n, output logic [31:0] rd);
    logic [17:0] ret;
    logic [31:0] exp_bits;
    bit          turbo;
    int          b0, a0;
    turbo    = m_cfg[1];
    ret      = m_arm ? {8'h00, m_cfg, 2'b00} : (turbo ? m_conv : smp);
    m_arm    = 1'b0;
    m_conv   = smp;
    exp_bits = frame_bits(ret, n);
    chk_en   = 1'b0;
    b0 = busy_total;
    a0 = ack_total;
    sample_in = smp;
    cnv_pulse();
    cycles(turbo ? 8 : 80);
    shift_bits(n, cmd, rd);
    check({name, "_sdo_bits"}, rd, exp_bits);
    check({name, "_busy_cycles"}, 32'(busy_total - b0), turbo ? 32'd0 : 32'd64);
    check({name, "_acks"}, 32'(ack_total - a0), 32'd1);
    if (n >= 16) begin
      if (cmd[15:8] == 8'h14)      m_cfg = cmd[7:0];
      else if (cmd[15:8] == 8'h54) m_arm = 1'b1;
    end
    cycles(2);
    chk_en = 1'b1;
  endtask

  task automatic model_reset();
    m_cfg  = 8'h00;
    m_conv = '0;
    m_arm  = 1'b0;
    m_err  = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int b0, a0;

    rst_n = 1'b0;
    adc_if.cnv = 1'b0;
    adc_if.sck = 1'b0;
    adc_if.sdi = 1'b0;
    sample_in  = '0;
    model_reset();
    cycles(5);
    rst_n = 1'b1;
    cycles(5);

    check("reset_sdo", 32'(adc_if.sdo), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(sample_ack), 32'd0);
    check("reset_cfg", 32'(cfg_reg), 32'h00);
    check("reset_cnv_err", 32'(cnv_err), 32'd0);
    chk_en = 1'b1;

    // Non-turbo conversion
    do_frame("nonturbo", 18'h2A5A5, 16'h0000, 18, rd);
    check("nonturbo_literal", rd, 32'h2A5A5);

    // Register write enables turbo + clamp disable
    do_frame("write_cfg", 18'h3FFFF, 16'h1403, 18, rd);
    check("write_cfg_literal", 32'(cfg_reg), 32'h03);

    // Turbo returns the previous conversion, busy never rises
    do_frame("turbo1", 18'h00001, 16'h0000, 18, rd);
    check("turbo1_literal", rd, 32'h3FFFF);
    do_frame("turbo2", 18'h00002, 16'h0000, 18, rd);
    check("turbo2_literal", rd, 32'h00001);

    // Read-back, one frame only
    do_frame("rd_arm", 18'h00003, 16'h5400, 18, rd);
    do_frame("rd_back", 18'h00004, 16'h0000, 18, rd);
    check("rd_back_literal", rd, 32'h0000C);
    do_frame("rd_after", 18'h00005, 16'h0000, 18, rd);
    check("rd_after_literal", rd, 32'h00004);

    // Short frame carrying a write is discarded
    do_frame("short", 18'h00006, 16'h14FF, 10, rd);
    check("short_cfg_kept", 32'(cfg_reg), 32'h03);

    // Back to non-turbo, clamp disable kept
    do_frame("write_cfg01", 18'h00007, 16'h1401, 18, rd);

    // Over-long frame: trailing bits read zero
    do_frame("long20", 18'h3FFFF, 16'h0000, 20, rd);
    check("long20_tail_zero", rd & 32'h3, 32'h0);

    // CNV during conversion is ignored and flagged
    chk_en = 1'b0;
    b0 = busy_total;
    a0 = ack_total;
    sample_in = 18'h15555;
    cnv_pulse();
    cycles(20);
    sample_in = 18'h0AAAA;
    cnv_pulse();
    cycles(80);
    shift_bits(18, 16'h0000, rd);
    check("cnv_busy_data", rd, 32'h15555);
    check("cnv_busy_acks", 32'(ack_total - a0), 32'd1);
    check("cnv_busy_busy_cycles", 32'(busy_total - b0), 32'd64);
    check("cnv_busy_err", 32'(cnv_err), 32'd1);
    m_conv = 18'h15555;
    m_err  = 1'b1;
    chk_en = 1'b1;

    // Reset in the middle of a frame
    chk_en = 1'b0;
    sample_in = 18'h3FFFF;
    cnv_pulse();
    cycles(80);
    shift_bits(7, 16'h0000, rd);
    check("pre_reset_sdo", 32'(adc_if.sdo), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_sdo", 32'(adc_if.sdo), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_cfg", 32'(cfg_reg), 32'h00);
    check("midreset_cnv_err", 32'(cnv_err), 32'd0);
    cycles(5);
    rst_n = 1'b1;
    model_reset();
    cycles(5);
    chk_en = 1'b1;
    do_frame("post_reset", 18'h12345, 16'h0000, 18, rd);
    check("post_reset_literal", rd, 32'h12345);

    // CNV landing exactly on the terminal count: a new conversion starts, no error
    chk_en = 1'b0;
    b0 = busy_total;
    a0 = ack_total;
    sample_in = 18'h11111;
    cycles(1);
    adc_if.cnv = 1'b1;
    cycles(4);
    adc_if.cnv = 1'b0;
    sample_in = 18'h22222;
    cycles(60);
    adc_if.cnv = 1'b1;
    cycles(4);
    adc_if.cnv = 1'b0;
    cycles(140);
    shift_bits(18, 16'h0000, rd);
    check("term_cnv_data", rd, 32'h22222);
    check("term_cnv_acks", 32'(ack_total - a0), 32'd2);
    check("term_cnv_busy_cycles", 32'(busy_total - b0), 32'd128);
    check("term_cnv_err", 32'(cnv_err), 32'd0);
    m_conv = 18'h22222;
    chk_en = 1'b1;
    cycles(4);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
